// File: rtl/serial_subtractor_if.sv
// Ready/valid operand and result channels for the bit-serial subtractor.
// master = producer/consumer side, slave = subtractor side.
interface serial_subtractor_if #(
   parameter int N = 8
);
   logic         i_valid;
   logic         o_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         o_valid;
   logic         i_ready;
   logic [N-1:0] diff;
   logic         borrow;
   logic         overflow;

   modport master (
      output i_valid, a, b, i_ready,
      input  o_ready, o_valid, diff, borrow, overflow
   );

   modport slave (
      input  i_valid, a, b, i_ready,
      output o_ready, o_valid, diff, borrow, overflow
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell plus a registered borrow.
// state | meaning
// IDLE  | o_ready high, waiting for operands
// SHIFT | one operand bit per clock, N clocks
// DONE  | o_valid high, result held until i_ready
module serial_subtractor #(
   parameter int N = 8
) (
   input logic                clk,
   input logic                rst,
   serial_subtractor_if.slave bus
);
   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t       state;
   state_t       state_nxt;
   logic [N-1:0] a_sh;
   logic [N-1:0] b_sh;
   logic [N-1:0] res_sh;
   logic [N-1:0] diff_q;
   logic [CW-1:0] cnt;
   logic         bw;
   logic         borrow_q;
   logic         overflow_q;
   logic         a_msb;
   logic         b_msb;
   logic         x;
   logic         y;
   logic         d;
   logic         bw_nxt;
   logic         last_bit;
   logic         accept;
   logic         ready_c;
   logic         valid_c;

   assign x        = a_sh[0];
   assign y        = b_sh[0];
   assign d        = x ^ y ^ bw;
   assign bw_nxt   = (~x & y) | (~(x ^ y) & bw);
   assign last_bit = (cnt == CW'(N - 1));
   assign accept   = (state == IDLE) && bus.i_valid;

   always_comb begin
      state_nxt = state;
      ready_c   = 1'b0;
      valid_c   = 1'b0;
      case (state)
         IDLE: begin
            ready_c = 1'b1;
            if (bus.i_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (last_bit) state_nxt = DONE;
         end
         DONE: begin
            valid_c = 1'b1;
            if (bus.i_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_sh       <= '0;
         b_sh       <= '0;
         res_sh     <= '0;
         diff_q     <= '0;
         cnt        <= '0;
         bw         <= 1'b0;
         borrow_q   <= 1'b0;
         overflow_q <= 1'b0;
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
      end else if (accept) begin
         a_sh   <= bus.a;
         b_sh   <= bus.b;
         a_msb  <= bus.a[N-1];
         b_msb  <= bus.b[N-1];
         res_sh <= '0;
         bw     <= 1'b0;
         cnt    <= '0;
      end else if (state == SHIFT) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         res_sh <= {d, res_sh[N-1:1]};
         bw     <= bw_nxt;
         if (!last_bit) begin
            cnt <= cnt + CW'(1);
         end else begin
            // The final cell output is the result MSB; the operand MSBs were saved at accept.
            diff_q     <= {d, res_sh[N-1:1]};
            borrow_q   <= bw_nxt;
            overflow_q <= (a_msb ^ b_msb) & (d ^ a_msb);
         end
      end
   end

   assign bus.o_ready  = ready_c;
   assign bus.o_valid  = valid_c;
   assign bus.diff     = diff_q;
   assign bus.borrow   = borrow_q;
   assign bus.overflow = overflow_q;
endmodule
